// File: rtl/shift_pkg.sv
// Shared definitions for the leading-count normalizer.
// Widths, ALU mode encodings and FSM states.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int STEP_DEF  = 4;

  localparam logic [1:0] MODE_CLZ = 2'b00;
  localparam logic [1:0] MODE_CLO = 2'b01;
  localparam logic [1:0] MODE_CLS = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/clz_step.sv
// STEP-bit leading-zero priority encoder.
// z is the zero run above the highest set bit.
module clz_step #(
  parameter int STEP = 4,
  parameter int ZW   = 2
) (
  input  logic [STEP-1:0] t_i,
  output logic [ZW-1:0]   z_o,
  output logic            all_zero_o
);

  // highest set bit wins: later iterations override
  always_comb begin
    z_o = '0;
    for (int i = 0; i < STEP; i++) begin
      if (t_i[i]) z_o = ZW'(STEP - 1 - i);
    end
  end

  assign all_zero_o = (t_i == '0);

endmodule

// File: rtl/clz_normalizer.sv
// Iterative CLZ/CLO/CLS unit; emits shift count and normalized word.
// Scans STEP bits per cycle from the MSB.
module clz_normalizer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero
);

  localparam int ZW = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - STEP);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] norm_q;
  logic             zero_q;

  logic [WIDTH-1:0] w_d;
  logic [STEP-1:0]  t;
  logic [ZW-1:0]    z;
  logic             all_zero;

  // scan word for the requested mode; mode 11 falls back to CLZ
  always_comb begin
    w_d = in_data;
    unique case (in_mode)
      MODE_CLO: w_d = ~in_data;
      MODE_CLS: w_d = (in_data ^ (in_data << 1)) | WIDTH'(1);
      default:  w_d = in_data;
    endcase
  end

  assign t = w_q[WIDTH-1 -: STEP];

  clz_step #(
    .STEP (STEP),
    .ZW   (ZW)
  ) u_step (
    .t_i        (t),
    .z_o        (z),
    .all_zero_o (all_zero)
  );

  // FSM plus scan datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            w_q     <= w_d;
            s_q     <= in_data;
            cnt_q   <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!all_zero) begin
            cnt_q   <= cnt_q + CNT_W'(z);
            s_q     <= s_q << z;
            count_q <= cnt_q + CNT_W'(z);
            norm_q  <= s_q << z;
            zero_q  <= 1'b0;
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_FULL;
            s_q     <= '0;
            count_q <= CNT_FULL;
            norm_q  <= '0;
            zero_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_STEP;
            w_q   <= w_q << STEP;
            s_q   <= s_q << STEP;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_count = count_q;
  assign out_norm  = norm_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Directed-vector bench for clz_normalizer.
// Table of ops plus backpressure and async-reset sequences.
module tb_clz_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic [31:0] out_norm;
  logic        out_zero;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [5:0]  cnt;
    logic [31:0] norm;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  clz_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_norm  (out_norm),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // accept one op, scramble inputs afterwards, wait for out_valid
  task automatic issue(input logic [1:0] m,
                       input logic [31:0] d,
                       output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_mode  = ~m;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;

    vecs[0]  = '{2'b00, 32'h0001_0000, 6'd15, 32'h8000_0000, 1'b0, 4};
    vecs[1]  = '{2'b00, 32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1, 8};
    vecs[2]  = '{2'b00, 32'h8000_0000, 6'd0,  32'h8000_0000, 1'b0, 1};
    vecs[3]  = '{2'b01, 32'hFFF0_1234, 6'd12, 32'h0123_4000, 1'b0, 4};
    vecs[4]  = '{2'b11, 32'h0F00_0000, 6'd4,  32'hF000_0000, 1'b0, 2};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFF, 6'd31, 32'h8000_0000, 1'b0, 8};
    vecs[6]  = '{2'b10, 32'h0000_0001, 6'd30, 32'h4000_0000, 1'b0, 8};
    vecs[7]  = '{2'b10, 32'h0000_0000, 6'd31, 32'h0000_0000, 1'b0, 8};
    vecs[8]  = '{2'b10, 32'hC000_0000, 6'd1,  32'h8000_0000, 1'b0, 1};
    vecs[9]  = '{2'b00, 32'h0000_00FF, 6'd24, 32'hFF00_0000, 1'b0, 7};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 1'b1, 8};
    vecs[11] = '{2'b00, 32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0, 8};

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_norm", 64'(out_norm), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].mode, vecs[i].data, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_count", i), 64'(out_count), 64'(vecs[i].cnt));
      chk($sformatf("v%0d_norm", i), 64'(out_norm), 64'(vecs[i].norm));
      chk($sformatf("v%0d_zero", i), 64'(out_zero), 64'(vecs[i].zero));
      release_out();
    end

    // backpressure: hold result, ignore pulsed requests
    issue(2'b00, 32'h0001_0000, lat);
    chk("bp_lat", 64'(lat), 64'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c % 2 == 0);
      in_data  = 32'h0000_0003;
      in_mode  = 2'b00;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_count", 64'(out_count), 64'd15);
      chk("bp_norm", 64'(out_norm), 64'h8000_0000);
      chk("bp_zero", 64'(out_zero), 64'd0);
    end
    release_out();
    issue(2'b01, 32'hFFF0_1234, lat);
    chk("bp_next_lat", 64'(lat), 64'd4);
    chk("bp_next_count", 64'(out_count), 64'd12);
    chk("bp_next_norm", 64'(out_norm), 64'h0123_4000);
    release_out();

    // async reset during the third scan cycle of CLZ 0
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = 32'h0000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_count", 64'(out_count), 64'd0);
    chk("ar_norm", 64'(out_norm), 64'd0);
    chk("ar_zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'h0000_00FF, lat);
    chk("ar_next_lat", 64'(lat), 64'd7);
    chk("ar_next_count", 64'(out_count), 64'd24);
    chk("ar_next_norm", 64'(out_norm), 64'hFF00_0000);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
